// File: rtl/pc_adjust.sv
// -----------------------------------------------------------------------------
// pc_adjust : next-program-counter selector for the 16-bit RISC core.
//
// Produces a registered next PC from the current PC and a jump operand:
//   select = 2'b00 : PC + 1               (sequential, wraps 0xFFFF -> 0x0000)
//   select = 2'b01 : jumpAddr             (absolute jump, optional call push)
//   select = 2'b10 : PC + jumpAddr        (relative, jumpAddr is two's-complement)
//   select = 2'b11 : return (stack build) or hold (no-stack build)
//
// Optional feature macro: PCADJUST_RAS_EN
//   defined   : RAS_DEPTH-entry circular LIFO return-address stack is built.
//   undefined : no storage; select=11 holds, ras_empty=1, ras_full=0.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   en         in   1   update enable; 0 stalls every piece of state
//   PC         in  16   current program counter
//   jumpAddr   in  16   absolute target or relative offset
//   select     in   2   target source (see above)
//   call       in   1   with select=01, push PC+1 (stack build only)
//   adjustedPC out 16   registered next PC
//   ras_empty  out  1   stack holds no entries
//   ras_full   out  1   stack holds RAS_DEPTH entries
// -----------------------------------------------------------------------------
module pc_adjust #(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] PC,
  input  logic [15:0] jumpAddr,
  input  logic [1:0]  select,
  input  logic        call,
  output logic [15:0] adjustedPC,
  output logic        ras_empty,
  output logic        ras_full
);

  logic [15:0] r_pc;
  logic [15:0] w_nxt;
  logic [15:0] w_seq;

  assign w_seq      = PC + 16'd1;
  assign adjustedPC = r_pc;

`ifdef PCADJUST_RAS_EN
  localparam int          PW      = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

  // r_ptr is the next write slot; the top of stack sits one slot below it.
  // It wraps modulo RAS_DEPTH, so a push when full overwrites the oldest entry.
  logic [15:0]   r_stack [RAS_DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_count;
  logic          r_empty;
  logic          r_full;

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_top_idx;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW:0]   w_cnt_nxt;

  assign w_top_idx = r_ptr - {{(PW-1){1'b0}}, 1'b1};
  assign ras_empty = r_empty;
  assign ras_full  = r_full;

  // Next-PC select plus push/pop decode.
  always_comb begin
    w_nxt  = w_seq;
    w_push = 1'b0;
    w_pop  = 1'b0;
    case (select)
      2'b00: w_nxt = w_seq;
      2'b01: begin
        w_nxt  = jumpAddr;
        w_push = call;
      end
      2'b10: w_nxt = PC + jumpAddr;
      2'b11: begin
        if (r_count != {(PW+1){1'b0}}) begin
          w_nxt = r_stack[w_top_idx];
          w_pop = 1'b1;
        end else begin
          w_nxt = w_seq;
        end
      end
      default: w_nxt = w_seq;
    endcase
  end

  // Stack pointer and occupancy update; occupancy saturates at RAS_DEPTH.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_count;
    if (w_push) begin
      w_ptr_nxt = r_ptr + {{(PW-1){1'b0}}, 1'b1};
      if (r_count == DEPTH_C) begin
        w_cnt_nxt = r_count;
      end else begin
        w_cnt_nxt = r_count + {{PW{1'b0}}, 1'b1};
      end
    end else if (w_pop) begin
      w_ptr_nxt = w_top_idx;
      w_cnt_nxt = r_count - {{PW{1'b0}}, 1'b1};
    end else begin
      w_ptr_nxt = r_ptr;
      w_cnt_nxt = r_count;
    end
  end

  // Stack control state and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= {PW{1'b0}};
      r_count <= {(PW+1){1'b0}};
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else if (en) begin
      r_ptr   <= w_ptr_nxt;
      r_count <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == {(PW+1){1'b0}});
      r_full  <= (w_cnt_nxt == DEPTH_C);
    end else begin
      r_ptr   <= r_ptr;
      r_count <= r_count;
      r_empty <= r_empty;
      r_full  <= r_full;
    end
  end

  // Stack storage; contents are only meaningful below r_count, so no reset.
  always_ff @(posedge clk) begin
    if (en && w_push) begin
      r_stack[r_ptr] <= w_seq;
    end
  end
`else
  logic w_unused_call;
  logic [$clog2(RAS_DEPTH):0] w_unused_depth;

  assign w_unused_call  = call;
  assign w_unused_depth = '0;
  assign ras_empty      = 1'b1;
  assign ras_full       = 1'b0;

  // Next-PC select; without a stack, select=11 holds the current value.
  always_comb begin
    w_nxt = w_seq;
    case (select)
      2'b00:   w_nxt = w_seq;
      2'b01:   w_nxt = jumpAddr;
      2'b10:   w_nxt = PC + jumpAddr;
      2'b11:   w_nxt = r_pc;
      default: w_nxt = w_seq;
    endcase
  end
`endif

  // Output PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= 16'h0000;
    end else if (en) begin
      r_pc <= w_nxt;
    end else begin
      r_pc <= r_pc;
    end
  end

endmodule

// File: tb/tb_pc_adjust.sv
// -----------------------------------------------------------------------------
// tb_pc_adjust : scoreboard bench for pc_adjust. The driver pushes the
// hand-computed expected outputs for each applied cycle; a monitor pops one
// entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_pc_adjust;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] PC;
  logic [15:0] jumpAddr;
  logic [1:0]  select;
  logic        call;
  logic [15:0] adjustedPC;
  logic        ras_empty;
  logic        ras_full;

  typedef struct packed {
    logic [15:0] pc;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  pc_adjust #(.RAS_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .PC         (PC),
    .jumpAddr   (jumpAddr),
    .select     (select),
    .call       (call),
    .adjustedPC (adjustedPC),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expected entry per applied cycle, checked just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("adjustedPC", adjustedPC, e.pc);
      chk("ras_empty", {15'd0, ras_empty}, {15'd0, e.empty});
      chk("ras_full", {15'd0, ras_full}, {15'd0, e.full});
    end
  end

  task automatic step(input logic [1:0] sel, input logic [15:0] pc, input logic [15:0] ja,
                      input logic cl, input logic e_n, input logic [15:0] xpc,
                      input logic xe, input logic xf);
    exp_t e;
    @(negedge clk);
    select   = sel;
    PC       = pc;
    jumpAddr = ja;
    call     = cl;
    en       = e_n;
    e.pc = xpc; e.empty = xe; e.full = xf;
    sb_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; PC = 16'h0000; jumpAddr = 16'h0000;
    select = 2'b00; call = 1'b0;
    // Reset asserted between edges
    #2 rst_n = 1'b0;
    #1;
    chk("reset_pc", adjustedPC, 16'h0000);
    chk("reset_empty", {15'd0, ras_empty}, 16'h0001);
    chk("reset_full", {15'd0, ras_full}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Basic select patterns
    step(2'b00, 16'h0080, 16'h8808, 1'b0, 1'b1, 16'h0081, 1'b1, 1'b0);
    step(2'b01, 16'h0080, 16'h8808, 1'b0, 1'b1, 16'h8808, 1'b1, 1'b0);
    step(2'b10, 16'h0080, 16'h8808, 1'b0, 1'b1, 16'h8888, 1'b1, 1'b0);
`ifdef PCADJUST_RAS_EN
    // Empty stack: return falls back to PC+1
    step(2'b11, 16'h0080, 16'h8808, 1'b0, 1'b1, 16'h0081, 1'b1, 1'b0);
`else
    step(2'b11, 16'h0080, 16'h8808, 1'b0, 1'b1, 16'h8888, 1'b1, 1'b0);
    step(2'b11, 16'h0400, 16'h0001, 1'b1, 1'b1, 16'h8888, 1'b1, 1'b0);
    // call ignored without the stack
    step(2'b01, 16'h0400, 16'h1111, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b0);
`endif
    // Wraps
    step(2'b00, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    step(2'b10, 16'h0010, 16'hFFF0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    step(2'b10, 16'h0100, 16'hFFFE, 1'b0, 1'b1, 16'h00FE, 1'b1, 1'b0);
    step(2'b01, 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h4321, 1'b1, 1'b0);
    // Stall for 3 cycles while inputs change
    step(2'b00, 16'h5555, 16'h0001, 1'b0, 1'b0, 16'h4321, 1'b1, 1'b0);
    step(2'b10, 16'h6666, 16'h0100, 1'b1, 1'b0, 16'h4321, 1'b1, 1'b0);
    step(2'b01, 16'h7777, 16'h9999, 1'b1, 1'b0, 16'h4321, 1'b1, 1'b0);
    step(2'b00, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0);

`ifdef PCADJUST_RAS_EN
    // call with non-jump select does not push
    step(2'b00, 16'h0900, 16'h0000, 1'b1, 1'b1, 16'h0901, 1'b1, 1'b0);
    // Three calls then three returns then return on empty
    step(2'b01, 16'h0100, 16'h1000, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b0);
    step(2'b01, 16'h0200, 16'h2000, 1'b1, 1'b1, 16'h2000, 1'b0, 1'b0);
    step(2'b01, 16'h0300, 16'h3000, 1'b1, 1'b1, 16'h3000, 1'b0, 1'b0);
    // Stalled return must not pop
    step(2'b11, 16'h0999, 16'h0000, 1'b0, 1'b0, 16'h3000, 1'b0, 1'b0);
    step(2'b11, 16'h3005, 16'h0000, 1'b0, 1'b1, 16'h0301, 1'b0, 1'b0);
    step(2'b11, 16'h0205, 16'h0000, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b0);
    step(2'b11, 16'h0105, 16'h0000, 1'b0, 1'b1, 16'h0101, 1'b1, 1'b0);
    step(2'b11, 16'h0050, 16'h0000, 1'b0, 1'b1, 16'h0051, 1'b1, 1'b0);
    // Overflow: five calls into a four-deep stack
    step(2'b01, 16'h0001, 16'h2000, 1'b1, 1'b1, 16'h2000, 1'b0, 1'b0);
    step(2'b01, 16'h0002, 16'h2000, 1'b1, 1'b1, 16'h2000, 1'b0, 1'b0);
    step(2'b01, 16'h0003, 16'h2000, 1'b1, 1'b1, 16'h2000, 1'b0, 1'b0);
    step(2'b01, 16'h0004, 16'h2000, 1'b1, 1'b1, 16'h2000, 1'b0, 1'b1);
    step(2'b01, 16'h0005, 16'h2000, 1'b1, 1'b1, 16'h2000, 1'b0, 1'b1);
    step(2'b11, 16'h2000, 16'h0000, 1'b0, 1'b1, 16'h0006, 1'b0, 1'b0);
    step(2'b11, 16'h0006, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
    step(2'b11, 16'h0005, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0);
    step(2'b11, 16'h0004, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0);
    // Leave one entry pending so mid-operation reset has state to discard
    step(2'b01, 16'h0AAA, 16'h0BBB, 1'b1, 1'b1, 16'h0BBB, 1'b0, 1'b0);
`endif

    // Let the monitor drain, then assert reset between edges
    @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
    end
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_pc", adjustedPC, 16'h0000);
    chk("midreset_empty", {15'd0, ras_empty}, 16'h0001);
    chk("midreset_full", {15'd0, ras_full}, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    // After reset the stack is empty, so a return gives PC+1 (or hold at 0)
`ifdef PCADJUST_RAS_EN
    step(2'b11, 16'h0040, 16'h0000, 1'b0, 1'b1, 16'h0041, 1'b1, 1'b0);
`else
    step(2'b11, 16'h0040, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
`endif
    step(2'b00, 16'h0041, 16'h0000, 1'b0, 1'b1, 16'h0042, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
